// File: rtl/riscv_lsu.sv
// Load/store unit: sized, aligned accesses to a wait-stated data memory over a valid/ready
// request with a separate read-data-valid return, pipeline stall, error reporting and bus timeout.
module riscv_lsu #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 8,
  parameter int P_TIMEOUT         = 15
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_req_valid,
  input  logic                         i_req_we,
  input  logic [2:0]                   i_req_funct3,
  input  logic [31:0]                  i_req_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_req_wdata,
  output logic                         o_stall,
  output logic [P_DATA_WIDTH-1:0]      o_rdata,
  output logic                         o_rdata_valid,
  output logic [1:0]                   o_lsu_err,
  output logic                         o_dmem_valid,
  input  logic                         i_dmem_ready,
  output logic                         o_dmem_we,
  output logic [3:0]                   o_dmem_be,
  output logic [P_DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [P_DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                         i_dmem_rvalid,
  input  logic [P_DATA_WIDTH-1:0]      i_dmem_rdata
);

  if (P_DATA_WIDTH != 32) begin : g_width_check
    $error("riscv_lsu: P_DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] LP_ERR_OK       = 2'b00;
  localparam logic [1:0] LP_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LP_ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] LP_ERR_TIMEOUT  = 2'b11;

  localparam int LP_CW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

  state_t                         r_state;
  logic [LP_CW-1:0]               r_cnt;
  logic                           r_we;
  logic [2:0]                     r_funct3;
  logic [1:0]                     r_addr_lo;
  logic [P_DMEM_ADDR_WIDTH-1:0]   r_dmem_addr;
  logic [3:0]                     r_be;
  logic [P_DATA_WIDTH-1:0]        r_wdata;
  logic [P_DATA_WIDTH-1:0]        r_rdata;
  logic                           r_timeout_err;

  logic                           w_illegal;
  logic                           w_misaligned;
  logic                           w_idle_req;
  logic                           w_accept;
  logic                           w_timeout;
  logic [3:0]                     w_be;
  logic [P_DATA_WIDTH-1:0]        w_wdata;
  logic [P_DATA_WIDTH-1:0]        w_lane;
  logic [P_DATA_WIDTH-1:0]        w_load_data;
  logic                           w_unused;

  // Loads reject 011/110/111; stores accept only 000/001/010.
  assign w_illegal    = i_req_we ? (i_req_funct3 >= 3'b011)
                                 : ((i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11));
  assign w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                        ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));

  // Gated by reset so a request presented during reset cannot raise stall or an error.
  assign w_idle_req = (r_state == S_IDLE) && i_req_valid && i_rst_n;
  assign w_accept   = w_idle_req && !w_illegal && !w_misaligned;
  assign w_timeout  = (P_TIMEOUT != 0) && (r_cnt == LP_CW'(P_TIMEOUT - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_req_wdata;
    case (i_req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {i_req_addr[1], 1'b0};
        w_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane = i_dmem_rdata >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load_data = w_lane;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load_data = {24'd0, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load_data = {16'd0, w_lane[15:0]};
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_funct3      <= 3'b000;
      r_addr_lo     <= 2'b00;
      r_dmem_addr   <= '0;
      r_be          <= 4'b0000;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timeout_err <= 1'b0;
          if (w_accept) begin
            r_we        <= i_req_we;
            r_funct3    <= i_req_funct3;
            r_addr_lo   <= i_req_addr[1:0];
            r_dmem_addr <= i_req_addr[P_DMEM_ADDR_WIDTH+1:2];
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_cnt       <= '0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_dmem_ready) begin
            r_cnt   <= '0;
            r_state <= r_we ? S_DONE : S_WAIT_R;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + LP_CW'(1);
          end
        end
        S_WAIT_R: begin
          if (i_dmem_rvalid) begin
            r_rdata <= w_load_data;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_rdata       <= '0;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + LP_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall       = (r_state == S_REQ) || (r_state == S_WAIT_R) || w_accept;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = (r_state == S_DONE) && !r_we;
  assign o_dmem_valid  = (r_state == S_REQ);
  assign o_dmem_we     = r_we;
  assign o_dmem_be     = r_be;
  assign o_dmem_addr   = r_dmem_addr;
  assign o_dmem_wdata  = r_wdata;

  always_comb begin
    o_lsu_err = LP_ERR_OK;
    if (r_state == S_DONE && r_timeout_err) o_lsu_err = LP_ERR_TIMEOUT;
    else if (w_idle_req && w_illegal)       o_lsu_err = LP_ERR_ILLEGAL;
    else if (w_idle_req && w_misaligned)    o_lsu_err = LP_ERR_MISALIGN;
  end

  assign w_unused = ^i_req_addr[31:P_DMEM_ADDR_WIDTH+2];

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: sized stores/loads, extension, error codes, timeout and reset abort.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid;
  logic [31:0] rdata;
  logic [1:0]  lsu_err;
  logic        dmem_valid, dmem_ready, dmem_we, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_lsu #(.P_DATA_WIDTH(32), .P_DMEM_ADDR_WIDTH(8), .P_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_we(req_we), .i_req_funct3(req_funct3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_stall(stall), .o_rdata(rdata), .o_rdata_valid(rdata_valid), .o_lsu_err(lsu_err),
    .o_dmem_valid(dmem_valid), .i_dmem_ready(dmem_ready), .o_dmem_we(dmem_we),
    .o_dmem_be(dmem_be), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
  endtask

  // Request stays asserted through DONE, as a stalled pipeline would present it.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [7:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wdata);
    cyc(); issue(1'b1, f3, addr, wdata);
    smp(); check({tag, " idle stall"}, 32'(stall), 32'd1);
           check({tag, " idle dvalid"}, 32'(dmem_valid), 32'd0);
    cyc(); dmem_ready = 1'b1;
    smp(); check({tag, " req dvalid"}, 32'(dmem_valid), 32'd1);
           check({tag, " req stall"}, 32'(stall), 32'd1);
           check({tag, " we"}, 32'(dmem_we), 32'd1);
           check({tag, " addr"}, 32'(dmem_addr), 32'(e_addr));
           check({tag, " be"}, 32'(dmem_be), 32'(e_be));
           check({tag, " wdata"}, dmem_wdata, e_wdata);
    cyc(); dmem_ready = 1'b0;
    smp(); check({tag, " done stall"}, 32'(stall), 32'd0);
           check({tag, " done dvalid"}, 32'(dmem_valid), 32'd0);
           check({tag, " done rvalid"}, 32'(rdata_valid), 32'd0);
           check({tag, " done err"}, 32'(lsu_err), 32'd0);
    cyc(); req_valid = 1'b0;
    smp(); check({tag, " after dvalid"}, 32'(dmem_valid), 32'd0);
           check({tag, " after stall"}, 32'(stall), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] mem, input int gap, input logic [7:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_data);
    cyc(); issue(1'b0, f3, addr, 32'h0);
    smp(); check({tag, " idle stall"}, 32'(stall), 32'd1);
    // rvalid coincident with ready carries decoy data and must be ignored
    cyc(); dmem_ready = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = ~mem;
    smp(); check({tag, " req dvalid"}, 32'(dmem_valid), 32'd1);
           check({tag, " we"}, 32'(dmem_we), 32'd0);
           check({tag, " addr"}, 32'(dmem_addr), 32'(e_addr));
           check({tag, " be"}, 32'(dmem_be), 32'(e_be));
    cyc(); dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    for (int i = 1; i < gap; i++) begin
      smp(); check({tag, " wait stall"}, 32'(stall), 32'd1);
             check({tag, " wait dvalid"}, 32'(dmem_valid), 32'd0);
      cyc();
    end
    dmem_rvalid = 1'b1; dmem_rdata = mem;
    smp(); check({tag, " wait rv stall"}, 32'(stall), 32'd1);
           check({tag, " early rvalid"}, 32'(rdata_valid), 32'd0);
    cyc(); dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    smp(); check({tag, " done rvalid"}, 32'(rdata_valid), 32'd1);
           check({tag, " done rdata"}, rdata, e_data);
           check({tag, " done stall"}, 32'(stall), 32'd0);
           check({tag, " done err"}, 32'(lsu_err), 32'd0);
    cyc(); req_valid = 1'b0;
    smp(); check({tag, " after rvalid"}, 32'(rdata_valid), 32'd0);
           check({tag, " rdata held"}, rdata, e_data);
           check({tag, " after dvalid"}, 32'(dmem_valid), 32'd0);
  endtask

  task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] e_err);
    cyc(); issue(we, f3, addr, 32'h11223344);
    smp(); check({tag, " err"}, 32'(lsu_err), 32'(e_err));
           check({tag, " stall"}, 32'(stall), 32'd0);
           check({tag, " dvalid"}, 32'(dmem_valid), 32'd0);
    cyc(); req_valid = 1'b0;
    smp(); check({tag, " next dvalid"}, 32'(dmem_valid), 32'd0);
           check({tag, " next err"}, 32'(lsu_err), 32'd0);
           check({tag, " next rvalid"}, 32'(rdata_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    cyc(); cyc();
    smp(); check("rst stall", 32'(stall), 32'd0);
           check("rst dvalid", 32'(dmem_valid), 32'd0);
           check("rst rvalid", 32'(rdata_valid), 32'd0);
           check("rst err", 32'(lsu_err), 32'd0);
           check("rst rdata", rdata, 32'h0);
    cyc(); rst_n = 1'b1;

    do_store("SW",  3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 8'h04, 4'b1111, 32'hDEAD_BEEF);
    do_store("SB",  3'b000, 32'h0000_0013, 32'h0000_005A, 8'h04, 4'b1000, 32'h5A5A_5A5A);
    do_store("SH",  3'b001, 32'h0000_0016, 32'h1234_BEEF, 8'h05, 4'b1100, 32'hBEEF_BEEF);
    do_store("SBhi", 3'b000, 32'hABC0_03FD, 32'hFFFF_FF77, 8'hFF, 4'b0010, 32'h7777_7777);

    do_load("LB",  3'b000, 32'h0000_0011, 32'h0000_F280, 2, 8'h04, 4'b0010, 32'hFFFF_FFF2);
    do_load("LHU", 3'b101, 32'h0000_0012, 32'h8001_ABCD, 1, 8'h04, 4'b1100, 32'h0000_8001);
    do_load("LH",  3'b001, 32'h0000_0012, 32'h8001_ABCD, 1, 8'h04, 4'b1100, 32'hFFFF_8001);
    do_load("LBU", 3'b100, 32'h0000_0013, 32'h9A00_0000, 1, 8'h04, 4'b1000, 32'h0000_009A);
    do_load("LW",  3'b010, 32'h0000_0020, 32'hCAFE_F00D, 3, 8'h08, 4'b1111, 32'hCAFE_F00D);

    err_case("LW mis",   1'b0, 3'b010, 32'h0000_0006, 2'b01);
    err_case("SH mis",   1'b1, 3'b001, 32'h0000_0011, 2'b01);
    err_case("S011 ill", 1'b1, 3'b011, 32'h0000_0000, 2'b10);
    err_case("S100 ill", 1'b1, 3'b100, 32'h0000_0000, 2'b10);
    err_case("L111 ill", 1'b0, 3'b111, 32'h0000_0003, 2'b10);
    err_case("L011 ill", 1'b0, 3'b011, 32'h0000_0001, 2'b10);

    // Load stalls in WAIT_R: abort zeroes the previously loaded CAFEF00D
    cyc(); issue(1'b0, 3'b010, 32'h0000_0044, 32'h0);
    cyc(); dmem_ready = 1'b1;
    cyc(); dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp(); check("TOW wait stall", 32'(stall), 32'd1);
             check("TOW wait rvalid", 32'(rdata_valid), 32'd0);
      cyc();
    end
    smp(); check("TOW err", 32'(lsu_err), 32'd3);
           check("TOW rvalid", 32'(rdata_valid), 32'd1);
           check("TOW rdata", rdata, 32'h0);
           check("TOW stall", 32'(stall), 32'd0);
    cyc(); req_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    smp(); check("TOW late err", 32'(lsu_err), 32'd0);
    cyc(); dmem_rvalid = 1'b0;
    smp(); check("TOW late rvalid", 32'(rdata_valid), 32'd0);
           check("TOW late rdata", rdata, 32'h0);

    // Store never sees ready: four REQ cycles then an aborted DONE
    cyc(); issue(1'b1, 3'b010, 32'h0000_0040, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      cyc();
      smp(); check("TOR req dvalid", 32'(dmem_valid), 32'd1);
             check("TOR req stall", 32'(stall), 32'd1);
    end
    cyc();
    smp(); check("TOR err", 32'(lsu_err), 32'd3);
           check("TOR dvalid", 32'(dmem_valid), 32'd0);
           check("TOR stall", 32'(stall), 32'd0);
           check("TOR rvalid", 32'(rdata_valid), 32'd0);
    cyc(); req_valid = 1'b0; dmem_ready = 1'b1;
    smp(); check("TOR late dvalid", 32'(dmem_valid), 32'd0);
           check("TOR late stall", 32'(stall), 32'd0);
    cyc(); dmem_ready = 1'b0;
    smp(); check("TOR late idle", 32'(dmem_valid), 32'd0);

    // Reset while waiting for read data: the in-flight load is dropped
    cyc(); issue(1'b0, 3'b010, 32'h0000_0030, 32'h0);
    cyc(); dmem_ready = 1'b1;
    cyc(); dmem_ready = 1'b0; req_valid = 1'b0;
    smp(); check("RST in wait", 32'(stall), 32'd1);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    smp(); check("RST stall", 32'(stall), 32'd0);
           check("RST dvalid", 32'(dmem_valid), 32'd0);
           check("RST rvalid", 32'(rdata_valid), 32'd0);
    cyc(); dmem_rvalid = 1'b0;
    smp(); check("RST late rvalid", 32'(rdata_valid), 32'd0);
           check("RST late rdata", rdata, 32'h0);
           check("RST late stall", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
